// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: RGB565 colours, pack FSM states, counter-width helper.
package img_pkg;

    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_BLACK = 16'h0000;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pack_state_e;

    // A 1-entry dimension still needs a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_pos_cnt.sv
// Column/row tracker for a raster stream; flags the last pixel and the border band around
// the frame for the position of the beat currently presented.
module frame_pos_cnt
    import img_pkg::*;
#(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int BORDER = 2,
    localparam int COL_W = cnt_w(IMG_W),
    localparam int ROW_W = cnt_w(IMG_H)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic adv,
    output logic is_last,
    output logic is_border
);

    logic [COL_W-1:0] col_q, col_d, col_cur;
    logic [ROW_W-1:0] row_q, row_d, row_cur;
    logic             col_end;

    // clr makes this beat pixel (0,0), so flags and the increment use the restarted position.
    always_comb begin
        col_cur   = clr ? '0 : col_q;
        row_cur   = clr ? '0 : row_q;
        col_end   = (int'(col_cur) == IMG_W - 1);
        is_last   = col_end && (int'(row_cur) == IMG_H - 1);
        is_border = (int'(col_cur) < BORDER) || (int'(col_cur) >= IMG_W - BORDER) ||
                    (int'(row_cur) < BORDER) || (int'(row_cur) >= IMG_H - BORDER);
        col_d     = col_cur;
        row_d     = row_cur;
        if (adv) begin
            if (col_end) begin
                col_d = '0;
                row_d = is_last ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/edge_rgb_pack.sv
// Expands the 1-bit Sobel edge stream to RGB565 with border blanking, sop/eop regeneration
// and frame error flagging. Define EDGE_STAT_EN to add the per-frame edge pixel count.
module edge_rgb_pack
    import img_pkg::*;
#(
    parameter int          IMG_W      = 640,
    parameter int          IMG_H      = 480,
    parameter int          BORDER     = 2,
    parameter logic [15:0] EDGE_COLOR = RGB565_WHITE,
    parameter logic [15:0] BG_COLOR   = RGB565_BLACK
`ifdef EDGE_STAT_EN
    ,
    localparam int CW = $clog2(IMG_W * IMG_H + 1)
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          din_vld,
    input  logic          din_sop,
    input  logic          din_eop,
    output logic [15:0]   dout,
    output logic          dout_vld,
    output logic          dout_sop,
    output logic          dout_eop,
    output logic          frame_err
`ifdef EDGE_STAT_EN
    ,
    output logic [CW-1:0] edge_cnt,
    output logic          edge_cnt_vld
`endif
);

    pack_state_e state_q, state_d;
    logic        beat_ok, pos_clr, is_last, is_border, end_frame, is_edge_px;
    logic [15:0] dout_q, dout_d;
    logic        dout_vld_q, dout_vld_d;
    logic        dout_sop_q, dout_sop_d;
    logic        dout_eop_q, dout_eop_d;
    logic        frame_err_q, frame_err_d;

    frame_pos_cnt #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .BORDER (BORDER)
    ) u_pos (
        .clk       (clk),
        .rst       (rst),
        .clr       (pos_clr),
        .adv       (beat_ok),
        .is_last   (is_last),
        .is_border (is_border)
    );

    // In IDLE only a sop beat is taken; any sop restarts the position at (0,0).
    always_comb begin
        beat_ok     = din_vld && ((state_q == ACTIVE) || din_sop);
        pos_clr     = beat_ok && din_sop;
        end_frame   = din_eop || is_last;
        is_edge_px  = beat_ok && din && !is_border;
        state_d     = state_q;
        dout_d      = '0;
        dout_vld_d  = 1'b0;
        dout_sop_d  = 1'b0;
        dout_eop_d  = 1'b0;
        frame_err_d = 1'b0;
        if (beat_ok) begin
            dout_d      = is_edge_px ? EDGE_COLOR : BG_COLOR;
            dout_vld_d  = 1'b1;
            dout_sop_d  = din_sop;
            dout_eop_d  = end_frame;
            // eop must coincide with the last position; a sop while active restarts the frame.
            frame_err_d = (din_eop ^ is_last) || (din_sop && (state_q == ACTIVE));
            state_d     = end_frame ? IDLE : ACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            dout_sop_q  <= 1'b0;
            dout_eop_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            dout_sop_q  <= dout_sop_d;
            dout_eop_q  <= dout_eop_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign dout_sop  = dout_sop_q;
    assign dout_eop  = dout_eop_q;
    assign frame_err = frame_err_q;

`ifdef EDGE_STAT_EN
    logic [CW-1:0] acc_cnt_q, acc_cnt_d, cnt_sum;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic          edge_cnt_vld_q, edge_cnt_vld_d;

    // The running count includes the current beat, so the eop pixel lands in the latched total.
    always_comb begin
        cnt_sum        = (pos_clr ? '0 : acc_cnt_q) + CW'(is_edge_px);
        acc_cnt_d      = acc_cnt_q;
        edge_cnt_d     = edge_cnt_q;
        edge_cnt_vld_d = 1'b0;
        if (beat_ok) begin
            if (end_frame) begin
                edge_cnt_d     = cnt_sum;
                edge_cnt_vld_d = 1'b1;
                acc_cnt_d      = '0;
            end else begin
                acc_cnt_d      = cnt_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q      <= '0;
            edge_cnt_q     <= '0;
            edge_cnt_vld_q <= 1'b0;
        end else begin
            acc_cnt_q      <= acc_cnt_d;
            edge_cnt_q     <= edge_cnt_d;
            edge_cnt_vld_q <= edge_cnt_vld_d;
        end
    end

    assign edge_cnt     = edge_cnt_q;
    assign edge_cnt_vld = edge_cnt_vld_q;
`endif

endmodule

// File: tb/tb_edge_rgb_pack.sv
// Directed bench for edge_rgb_pack on a 4x3 frame with a 1-pixel border; with EDGE_STAT_EN a
// second BORDER=0 instance on the same stream exercises the edge statistics.
module tb_edge_rgb_pack;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 3;
    localparam int BORDER = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        din, din_vld, din_sop, din_eop;
    logic [15:0] dout;
    logic        dout_vld, dout_sop, dout_eop, frame_err;
`ifdef EDGE_STAT_EN
    localparam int CW = $clog2(IMG_W * IMG_H + 1);
    logic [CW-1:0] edge_cnt, s_edge_cnt;
    logic          edge_cnt_vld, s_edge_cnt_vld;
    logic [15:0]   s_dout;
    logic          s_dout_vld, s_dout_sop, s_dout_eop, s_frame_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    edge_rgb_pack #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .BORDER     (BORDER),
        .EDGE_COLOR (16'hFFFF),
        .BG_COLOR   (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_vld      (din_vld),
        .din_sop      (din_sop),
        .din_eop      (din_eop),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .dout_sop     (dout_sop),
        .dout_eop     (dout_eop),
        .frame_err    (frame_err)
`ifdef EDGE_STAT_EN
        ,
        .edge_cnt     (edge_cnt),
        .edge_cnt_vld (edge_cnt_vld)
`endif
    );

`ifdef EDGE_STAT_EN
    edge_rgb_pack #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .BORDER     (0),
        .EDGE_COLOR (16'hFFFF),
        .BG_COLOR   (16'h0000)
    ) dut_stat (
        .clk          (clk),
        .rst          (rst),
        .din          (din),
        .din_vld      (din_vld),
        .din_sop      (din_sop),
        .din_eop      (din_eop),
        .dout         (s_dout),
        .dout_vld     (s_dout_vld),
        .dout_sop     (s_dout_sop),
        .dout_eop     (s_dout_eop),
        .frame_err    (s_frame_err),
        .edge_cnt     (s_edge_cnt),
        .edge_cnt_vld (s_edge_cnt_vld)
    );
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One input beat; outputs are sampled 1 ns after the edge that registers it.
    task automatic step(input string tag, input logic v, input logic d, input logic s,
                        input logic e, input logic ev, input logic es, input logic ee,
                        input logic eerr, input logic [15:0] ed);
        din_vld = v;
        din     = d;
        din_sop = s;
        din_eop = e;
        @(posedge clk);
        #1;
        chk({tag, " vld/sop/eop/err"}, 32'({dout_vld, dout_sop, dout_eop, frame_err}),
            32'({ev, es, ee, eerr}));
        if (ev) chk({tag, " dout"}, 32'(dout), 32'(ed));
    endtask

    function automatic logic [15:0] interior(input int i);
        return (i == 5 || i == 6) ? 16'hFFFF : 16'h0000;
    endfunction

    task automatic good_frame(input string tag);
        for (int i = 0; i < 12; i++)
            step($sformatf("%s%0d", tag, i), 1, 1, i == 0, i == 11, 1, i == 0, i == 11, 0,
                 interior(i));
    endtask

    logic [11:0] stat_mask;
    int          k;

    initial begin
        rst = 1'b1; din = 1'b1; din_vld = 1'b1; din_sop = 1'b1; din_eop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", 32'({dout_vld, dout_sop, dout_eop, frame_err, dout}), 32'h0);
`ifdef EDGE_STAT_EN
        chk("reset edge_cnt", 32'({edge_cnt_vld, edge_cnt, s_edge_cnt_vld, s_edge_cnt}), 32'h0);
`endif
        rst = 1'b0;

        good_frame("good");
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);

        for (int i = 0; i < 8; i++)
            step($sformatf("early%0d", i), 1, 1, i == 0, i == 7, 1, i == 0, i == 7, i == 7,
                 interior(i));
        for (int i = 0; i < 3; i++)
            step($sformatf("early_drop%0d", i), 1, 1, 0, 0, 0, 0, 0, 0, 16'h0);

        for (int i = 0; i < 14; i++)
            step($sformatf("noeop%0d", i), 1, 1, i == 0, 0, i < 12, i == 0, i == 11, i == 11,
                 interior(i));

        for (int i = 0; i < 5; i++)
            step($sformatf("midsop_a%0d", i), 1, 1, i == 0, 0, 1, i == 0, 0, 0, interior(i));
        for (int j = 0; j < 12; j++)
            step($sformatf("midsop_b%0d", j), 1, 1, j == 0, j == 11, 1, j == 0, j == 11, j == 0,
                 interior(j));

        step("single", 1, 1, 1, 1, 1, 1, 1, 1, 16'h0);

        // Alternating din with random valid gaps; gap cycles carry stray sop/eop.
        k = 0;
        while (k < 12) begin
            if ($urandom_range(0, 2) == 0) begin
                step("gap", 0, 1'($urandom_range(0, 1)), 1, 1, 0, 0, 0, 0, 16'h0);
            end else begin
                step($sformatf("gapped%0d", k), 1, 1'(k % 2), k == 0, k == 11, 1, k == 0,
                     k == 11, 0, (k == 5) ? 16'hFFFF : 16'h0000);
                k++;
            end
        end

        for (int i = 0; i < 4; i++)
            step($sformatf("prerst%0d", i), 1, 1, i == 0, 0, 1, i == 0, 0, 0, 16'h0);
        rst = 1'b1; din_vld = 1'b1; din_sop = 1'b0; din_eop = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst outputs", 32'({dout_vld, dout_sop, dout_eop, frame_err, dout}), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step($sformatf("postrst_drop%0d", i), 1, 1, 0, i == 2, 0, 0, 0, 0, 16'h0);
        good_frame("postrst");

        // Edges only on border positions (beats 0,3,4,9,11): blank here, five edges unblanked.
        stat_mask = 12'hA19;
        for (int i = 0; i < 12; i++) begin
            step($sformatf("stat%0d", i), 1, stat_mask[i], i == 0, i == 11, 1, i == 0, i == 11,
                 0, 16'h0);
`ifdef EDGE_STAT_EN
            chk($sformatf("stat%0d s_dout", i), 32'({s_dout_vld, s_dout}),
                32'({1'b1, stat_mask[i] ? 16'hFFFF : 16'h0000}));
            chk($sformatf("stat%0d cnt_vld", i), 32'({edge_cnt_vld, s_edge_cnt_vld, s_dout_eop}),
                (i == 11) ? 32'h7 : 32'h0);
`endif
        end
`ifdef EDGE_STAT_EN
        chk("stat edge_cnt border1", 32'(edge_cnt), 32'd0);
        chk("stat edge_cnt border0", 32'(s_edge_cnt), 32'd5);
        step("stat_hold", 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        chk("stat hold", 32'({s_edge_cnt_vld, s_edge_cnt, s_frame_err}), 32'({1'b0, CW'(5), 1'b0}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
